// File: rtl/reg_dump_reader.sv
// Debug reader that walks a register file's dedicated read port and streams
// each captured word out as an (address, data) pair over valid/ready.
module reg_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  state_t st;

  assign state = st;

  // Handshake: a word transfers on any rising edge where out_valid and
  // out_ready are both high; while out_valid=1 and out_ready=0 the pair holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      st        <= IDLE;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rd_addr <= '0;
            busy    <= 1'b1;
            st      <= READ;
          end
        end
        READ: begin
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            rd_addr   <= '0;
            st        <= IDLE;
          end else begin
            // rd_addr has been stable for a full cycle, so rd_data is settled.
            out_data  <= rd_data;
            out_addr  <= rd_addr;
            out_valid <= 1'b1;
            st        <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            rd_addr   <= '0;
            st        <= IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (rd_addr == LAST_ADDR) begin
              // busy falls and done rises together with the last acceptance.
              busy <= 1'b0;
              done <= 1'b1;
              st   <= DONE;
            end else begin
              rd_addr <= rd_addr + ADDR_WIDTH'(1);
              st      <= READ;
            end
          end
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b0;
          st   <= IDLE;
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: a register-file array model, an expected (addr,data)
// queue built from that array, and a negedge monitor checking every transfer.
module tb_reg_dump_reader;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;
  localparam int BUDGET = 2000;

  logic          clock;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic [1:0]    state;

  logic [DW-1:0] regs [0:N-1];
  logic [AW+DW-1:0] exp_q[$];

  int  vectors;
  int  miscompares;
  int  done_count;
  bit  bp_en;

  reg_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(N)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .state(state)
  );

  // Register file: combinational read, address 0 hard-wired to zero.
  assign rd_data = (rd_addr == '0) ? '0 : regs[rd_addr];

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout/extra expected event", name);
  endtask

  // ---------------- random backpressure driver ----------------
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic          prev_stall;
    logic          prev_abort;
    logic          prev_done;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    logic [AW+DW-1:0] e;
    prev_stall = 1'b0;
    prev_abort = 1'b0;
    prev_done  = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_stall && !prev_abort) begin
          chk("stall_valid", 64'(out_valid), 64'(1));
          chk("stall_addr", 64'(out_addr), 64'(prev_addr));
          chk("stall_data", 64'(out_data), 64'(prev_data));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("extra_word");
          end else begin
            e = exp_q.pop_front();
            chk("word_addr", 64'(out_addr), 64'(e[AW+DW-1:DW]));
            chk("word_data", 64'(out_data), 64'(e[DW-1:0]));
          end
        end
        if (out_valid) chk("valid_implies_busy", 64'(busy), 64'(1));
        if (done) begin
          done_count++;
          chk("done_busy_low", 64'(busy), 64'(0));
          chk("done_single_cycle", 64'(prev_done), 64'(0));
        end
        chk("rd_addr_in_range", 64'(int'(rd_addr) <= N - 1), 64'(1));
        prev_stall = out_valid && !out_ready;
        prev_abort = abort;
        prev_done  = done;
        prev_addr  = out_addr;
        prev_data  = out_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_expected(input int wr_word);
    exp_q.delete();
    for (int a = 0; a < N; a++) begin
      logic [DW-1:0] d;
      d = (a == 0) ? '0 : regs[a];
      if (a == wr_word) d = 32'hDEADBEEF;
      exp_q.push_back({AW'(a), d});
    end
  endtask

  // One full dump. mid_start: pulse start while word mid_start is offered.
  // wr_word: write DEADBEEF on the falling edge while that address sits in READ.
  task automatic run_dump(input int mid_start, input int wr_word, input bit bp,
                          input bit timing, input bit pin);
    int  k;
    bit  got;
    bit  pulsed;
    bit  wrote;
    int  dc0;
    load_expected(wr_word);
    bp_en = bp;
    if (!bp) out_ready = 1'b1;
    dc0 = done_count;
    got = 1'b0;
    pulsed = 1'b0;
    wrote = 1'b0;
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    k = 0;
    while (k < BUDGET) begin
      @(negedge clock);
      if (timing && k == 0) begin
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_rd_addr", 64'(rd_addr), 64'(0));
        chk("start_valid", 64'(out_valid), 64'(0));
      end
      if (timing && k == 1) begin
        chk("first_valid", 64'(out_valid), 64'(1));
        chk("first_addr", 64'(out_addr), 64'(0));
      end
      if (pin && k == 1) chk("pin_word0", 64'(out_data), 64'(32'h0));
      if (pin && k == 3) begin
        chk("pin_addr1", 64'(out_addr), 64'(1));
        chk("pin_word1", 64'(out_data), 64'(32'hA5000001));
      end
      if (done) begin
        got = 1'b1;
        break;
      end
      if (wr_word >= 0 && !wrote && busy && !out_valid && int'(rd_addr) == wr_word) begin
        regs[wr_word] = 32'hDEADBEEF;
        wrote = 1'b1;
      end
      if (mid_start >= 0 && !pulsed && out_valid && int'(out_addr) == mid_start) begin
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        pulsed = 1'b1;
      end
      k++;
    end
    if (!got) fail_now("done_timeout");
    if (timing) chk("done_latency", 64'(k), 64'(2 * N));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    bp_en = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("after_done_low", 64'(done), 64'(0));
    chk("after_busy_low", 64'(busy), 64'(0));
    chk("after_idle", 64'(state), 64'(0));
    chk("done_count", 64'(done_count), 64'(dc0 + 1));
  endtask

  task automatic wait_offer(input int word, output bit found);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (out_valid && int'(out_addr) == word) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("wait_offer_timeout");
  endtask

  task automatic run_abort();
    bit found;
    int dc0;
    load_expected(-1);
    bp_en = 1'b0;
    out_ready = 1'b1;
    dc0 = done_count;
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_offer(6, found);
    @(posedge clock);
    #1 out_ready = 1'b0;
    @(posedge clock);
    #1 abort = 1'b1;
    @(negedge clock);
    chk("abort_hold_valid", 64'(out_valid), 64'(1));
    chk("abort_hold_addr", 64'(out_addr), 64'(7));
    @(posedge clock);
    #1 abort = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("abort_valid", 64'(out_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_rd_addr", 64'(rd_addr), 64'(0));
    chk("abort_idle", 64'(state), 64'(0));
    exp_q.delete();
    repeat (3) @(negedge clock);
    chk("abort_no_done", 64'(done_count), 64'(dc0));
  endtask

  task automatic run_reset();
    bit found;
    int dc0;
    load_expected(-1);
    bp_en = 1'b0;
    out_ready = 1'b1;
    dc0 = done_count;
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_offer(19, found);
    @(posedge clock);
    #1;
    chk("reset_read_addr", 64'(rd_addr), 64'(20));
    chk("reset_read_valid", 64'(out_valid), 64'(0));
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_rd_addr", 64'(rd_addr), 64'(0));
    chk("rst_outputs", 64'({out_valid, out_addr, busy, done}), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_state", 64'(state), 64'(0));
    exp_q.delete();
    repeat (3) @(negedge clock);
    chk("rst_no_done", 64'(done_count), 64'(dc0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    done_count = 0;
    bp_en = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) regs[i] = 32'hA5000000 + 32'(i);
    repeat (3) @(posedge clock);
    #1;
    chk("reset_rd_addr", 64'(rd_addr), 64'(0));
    chk("reset_flags", 64'({out_valid, busy, done}), 64'(0));
    chk("reset_out", 64'({out_addr, out_data}), 64'(0));
    chk("reset_state", 64'(state), 64'(0));
    reset = 1'b0;
    repeat (2) @(posedge clock);

    run_dump(-1, -1, 1'b0, 1'b1, 1'b1);
    run_dump(-1, -1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) regs[i] = $urandom;
    run_dump(-1, -1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) regs[i] = 32'hA5000000 + 32'(i);
    run_dump(10, -1, 1'b0, 1'b1, 1'b0);
    run_abort();
    run_dump(-1, -1, 1'b0, 1'b1, 1'b0);
    run_reset();
    run_dump(-1, -1, 1'b1, 1'b0, 1'b0);
    run_dump(-1, 5, 1'b0, 1'b1, 1'b0);
    regs[5] = 32'hA5000005;

    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
